prv_trap_ctrl: RTL and testbench
================================

Name: prv_trap_ctrl

Overview:
- Parametrised trap sequencer between the pipeline hazard unit and the machine-mode CSR file.
- Prioritises synchronous exceptions, N_INT maskable interrupts (level- or edge-type per source) and mret.
- Drains the pipeline through a flush/empty handshake, then performs a one-cycle PC insertion with commit strobes to the CSR file.
- Supports direct and vectored mtvec modes.

Parameters:
- XLEN, 32, datapath width of PCs and cause.
- N_INT, 12, number of interrupt sources; interrupt cause code = source index.
- IRQ_EDGE, 0, N_INT-bit mask; 1 = edge-triggered source with latched pending, 0 = level source.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- exc_vec  in  9  exception requests: [0]mal_insn(c0) [1]fault_insn(c1) [2]illegal_insn(c2) [3]breakpoint(c3) [4]mal_l(c4) [5]fault_l(c5) [6]mal_s(c6) [7]fault_s(c7) [8]env_m(c11)
- exc_pc  in  XLEN  PC of the faulting instruction
- mret  in  1  return request from the instruction in commit
- irq  in  N_INT  raw interrupt lines
- irq_en  in  N_INT  per-source enable (mie)
- global_ie  in  1  mstatus.MIE
- int_pc  in  XLEN  resume PC for an interrupt
- mtvec  in  XLEN  trap vector CSR
- mepc  in  XLEN  return target CSR
- pipe_empty  in  1  pipeline drained
- pipe_flush  out  1  flush request to hazard unit
- insert_pc  out  1  one-cycle PC redirect
- npc  out  XLEN  redirect target
- intr  out  1  current trap is an interrupt
- trap_commit  out  1  one-cycle strobe: CSR file writes mcause/mepc
- ret_commit  out  1  one-cycle strobe: CSR file restores on mret
- cause  out  XLEN  latched cause; MSB=1 for interrupt, low bits = code
- epc  out  XLEN  latched exception PC
- irq_pending  out  N_INT  effective pending vector (mip view)
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0; cause/epc/npc 0; edge-pending and irq_prev registers 0.
  - Reset mid-sequence aborts with no commit strobe.
- Effective pending per source i:
  - Level: irq[i].
  - Edge: pend[i], set on irq[i]&~irq_prev[i], cleared in the INSERT cycle that takes source i; set wins over clear in the same cycle.
- Interrupt eligible: global_ie & |(irq_pending & irq_en); the highest eligible index wins.
- Exception priority, high to low: bit 3,1,2,0,8,6,4,7,5 (cause c3,c1,c2,c0,c11,c6,c4,c7,c5).
- Event priority in IDLE: exception > interrupt > mret.
- IDLE, cycle T, event present:
  - Latch the event type and target.
  - Exception: cause={0,code}, epc=exc_pc, intr=0.
  - Interrupt: cause={1,idx}, epc=int_pc, intr=1.
  - mret: epc unchanged.
  - Go to DRAIN.
- DRAIN:
  - pipe_flush=1, busy=1.
  - Requests arriving here are ignored (edge pendings are retained).
  - pipe_empty=1 → INSERT next cycle.
  - No timeout: the state holds while pipe_empty=0.
- INSERT, exactly one cycle:
  - insert_pc=1, pipe_flush=1.
  - trap_commit=1 for a trap, ret_commit=1 for mret; never both.
  - Returns to IDLE.
  - Minimum latency: event at T → insert_pc at T+2 when pipe_empty is already 1.
- npc, registered when entering INSERT:
  - mret → mepc.
  - Trap with mtvec[1:0]==01 and interrupt → {mtvec[XLEN-1:2],00} + (idx<<2), modulo 2^XLEN.
  - Otherwise → {mtvec[XLEN-1:2],00}; modes 1x are treated as direct.
- mtvec and mepc are sampled in the DRAIN exit cycle.
- A new event may be accepted in the IDLE cycle immediately after INSERT.

Test Plan:
- exc_vec=9'h004, exc_pc=0x100, mtvec=0x8000_0001, pipe_empty=1 → insert_pc at T+2, npc=0x8000_0000, cause=2, epc=0x100, trap_commit=1, intr=0.
- exc_vec=9'h10A (breakpoint+fault_insn+env_m) → cause=3.
- N_INT=12, irq[11]&irq[7] level, irq_en=all, global_ie=1, mtvec=0x4001, int_pc=0x200 → cause=0x8000_000B, npc=0x402C, epc=0x200, intr=1.
- IRQ_EDGE[3]=1, irq[3] pulses 1 cycle with global_ie=0 → irq_pending[3] stays 1; setting global_ie=1 → trap taken and pending[3] clears in INSERT; a new edge in that same cycle leaves pending[3]=1.
- mret with mepc=0x1234 and pipe_empty held 0 for 5 cycles → pipe_flush high for those cycles, then insert_pc with npc=0x1234, ret_commit=1, trap_commit=0; a concurrent exception during DRAIN is ignored.
- RST asserted during DRAIN → all outputs 0 immediately, no commit strobe; mret and exception in the same IDLE cycle → exception taken.

Source files
------------

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap sequencer: prioritises exceptions, interrupts and mret,
// drains the pipeline, then issues a one-cycle PC insertion with CSR commit strobes.
module prv_trap_ctrl #(
    parameter int               XLEN     = 32,
    parameter int               N_INT    = 12,
    parameter logic [N_INT-1:0] IRQ_EDGE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [8:0]       exc_vec,
    input  logic [XLEN-1:0]  exc_pc,
    input  logic             mret,
    input  logic [N_INT-1:0] irq,
    input  logic [N_INT-1:0] irq_en,
    input  logic             global_ie,
    input  logic [XLEN-1:0]  int_pc,
    input  logic [XLEN-1:0]  mtvec,
    input  logic [XLEN-1:0]  mepc,
    input  logic             pipe_empty,
    output logic             pipe_flush,
    output logic             insert_pc,
    output logic [XLEN-1:0]  npc,
    output logic             intr,
    output logic             trap_commit,
    output logic             ret_commit,
    output logic [XLEN-1:0]  cause,
    output logic [XLEN-1:0]  epc,
    output logic [N_INT-1:0] irq_pending,
    output logic             busy
);

    localparam int IDXW = (N_INT > 1) ? $clog2(N_INT) : 1;

    // Handshake: pipe_flush stays high from DRAIN entry through the INSERT cycle;
    // the hazard unit answers with pipe_empty, and insert_pc/commit strobes are single-cycle.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_INSERT = 2'd2
    } state_t;

    state_t            state;
    logic              is_ret;
    logic [IDXW-1:0]   trap_idx;
    logic [N_INT-1:0]  pend;
    logic [N_INT-1:0]  irq_prev;
    logic [N_INT-1:0]  eligible;
    logic [N_INT-1:0]  pend_clr;
    logic [IDXW-1:0]   int_idx;
    logic              int_req;
    logic              exc_req;
    logic [3:0]        exc_code;
    logic [XLEN-1:0]   vec_base;

    assign irq_pending = (pend & IRQ_EDGE) | (irq & ~IRQ_EDGE);
    assign eligible    = irq_pending & irq_en;
    assign int_req     = global_ie & (|eligible);
    assign exc_req     = |exc_vec;
    assign vec_base    = {mtvec[XLEN-1:2], 2'b00};

    // Highest eligible index wins.
    always_comb begin
        int_idx = '0;
        for (int i = 0; i < N_INT; i++) begin
            if (eligible[i]) int_idx = IDXW'(i);
        end
    end

    always_comb begin
        exc_code = 4'd0;
        if (exc_vec[3])      exc_code = 4'd3;
        else if (exc_vec[1]) exc_code = 4'd1;
        else if (exc_vec[2]) exc_code = 4'd2;
        else if (exc_vec[0]) exc_code = 4'd0;
        else if (exc_vec[8]) exc_code = 4'd11;
        else if (exc_vec[6]) exc_code = 4'd6;
        else if (exc_vec[4]) exc_code = 4'd4;
        else if (exc_vec[7]) exc_code = 4'd7;
        else if (exc_vec[5]) exc_code = 4'd5;
    end

    always_comb begin
        pend_clr = '0;
        for (int i = 0; i < N_INT; i++) begin
            pend_clr[i] = (state == S_INSERT) && intr && (trap_idx == IDXW'(i));
        end
    end

    // A fresh edge in the clearing cycle keeps the source pending.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend     <= '0;
            irq_prev <= '0;
        end else begin
            irq_prev <= irq;
            pend     <= (pend & ~pend_clr) | (irq & ~irq_prev & IRQ_EDGE);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            is_ret      <= 1'b0;
            trap_idx    <= '0;
            pipe_flush  <= 1'b0;
            insert_pc   <= 1'b0;
            npc         <= '0;
            intr        <= 1'b0;
            trap_commit <= 1'b0;
            ret_commit  <= 1'b0;
            cause       <= '0;
            epc         <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exc_req || int_req || mret) begin
                        state      <= S_DRAIN;
                        pipe_flush <= 1'b1;
                        busy       <= 1'b1;
                    end
                    if (exc_req) begin
                        cause  <= XLEN'(exc_code);
                        epc    <= exc_pc;
                        intr   <= 1'b0;
                        is_ret <= 1'b0;
                    end else if (int_req) begin
                        cause    <= {1'b1, (XLEN-1)'(int_idx)};
                        epc      <= int_pc;
                        intr     <= 1'b1;
                        is_ret   <= 1'b0;
                        trap_idx <= int_idx;
                    end else if (mret) begin
                        intr   <= 1'b0;
                        is_ret <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) begin
                        state       <= S_INSERT;
                        insert_pc   <= 1'b1;
                        trap_commit <= ~is_ret;
                        ret_commit  <= is_ret;
                        if (is_ret)
                            npc <= mepc;
                        else if (intr && mtvec[1:0] == 2'b01)
                            npc <= vec_base + (XLEN'(trap_idx) << 2);
                        else
                            npc <= vec_base;
                    end
                end
                S_INSERT: begin
                    state       <= S_IDLE;
                    insert_pc   <= 1'b0;
                    trap_commit <= 1'b0;
                    ret_commit  <= 1'b0;
                    pipe_flush  <= 1'b0;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Directed bench for prv_trap_ctrl: a vector table of single traps plus
// hand-written sequences for edge pending, long drain, back-to-back and reset.
module tb_prv_trap_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [8:0]  exc_vec;
    logic [31:0] exc_pc;
    logic        mret;
    logic [11:0] irq;
    logic [11:0] irq_en;
    logic        global_ie;
    logic [31:0] int_pc;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        pipe_empty;
    logic        pipe_flush;
    logic        insert_pc;
    logic [31:0] npc;
    logic        intr;
    logic        trap_commit;
    logic        ret_commit;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [11:0] irq_pending;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    prv_trap_ctrl #(.XLEN(32), .N_INT(12), .IRQ_EDGE(12'h008)) dut (
        .CLK(CLK), .RST(RST), .exc_vec(exc_vec), .exc_pc(exc_pc), .mret(mret),
        .irq(irq), .irq_en(irq_en), .global_ie(global_ie), .int_pc(int_pc),
        .mtvec(mtvec), .mepc(mepc), .pipe_empty(pipe_empty),
        .pipe_flush(pipe_flush), .insert_pc(insert_pc), .npc(npc), .intr(intr),
        .trap_commit(trap_commit), .ret_commit(ret_commit), .cause(cause),
        .epc(epc), .irq_pending(irq_pending), .busy(busy)
    );

    // clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [8:0]  exc_vec;
        logic [31:0] exc_pc;
        logic        mret;
        logic [11:0] irq;
        logic [11:0] irq_en;
        logic        gie;
        logic [31:0] int_pc;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] e_npc;
        logic [31:0] e_cause;
        logic [31:0] e_epc;
        logic        e_intr;
        logic        e_tc;
        logic        e_rc;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic [8:0] ev, input logic [31:0] epc_i, input logic mr,
                                input logic [11:0] iq, input logic [11:0] ie, input logic g,
                                input logic [31:0] ipc, input logic [31:0] tv, input logic [31:0] mp,
                                input logic [31:0] x_npc, input logic [31:0] x_cause,
                                input logic [31:0] x_epc, input logic x_intr, input logic x_tc,
                                input logic x_rc);
        vec_t v;
        v.exc_vec = ev;  v.exc_pc = epc_i; v.mret = mr;  v.irq = iq;  v.irq_en = ie;
        v.gie = g;       v.int_pc = ipc;   v.mtvec = tv; v.mepc = mp;
        v.e_npc = x_npc; v.e_cause = x_cause; v.e_epc = x_epc;
        v.e_intr = x_intr; v.e_tc = x_tc; v.e_rc = x_rc;
        return v;
    endfunction

    // scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_req();
        exc_vec   = '0;
        mret      = 1'b0;
        irq       = '0;
        global_ie = 1'b0;
    endtask

    // Entered mid-cycle with the DUT idle; event cycle T, INSERT at T+2, IDLE at T+3.
    task automatic run_vec(input vec_t v, input int k);
        exc_vec = v.exc_vec; exc_pc = v.exc_pc; mret = v.mret; irq = v.irq;
        irq_en = v.irq_en; global_ie = v.gie; int_pc = v.int_pc;
        mtvec = v.mtvec; mepc = v.mepc; pipe_empty = 1'b1;
        step();
        clear_req();
        @(negedge CLK);
        chk($sformatf("v%0d_drain_flush", k), 32'(pipe_flush), 32'd1);
        chk($sformatf("v%0d_drain_busy", k), 32'(busy), 32'd1);
        chk($sformatf("v%0d_drain_ins", k), 32'(insert_pc), 32'd0);
        step();
        @(negedge CLK);
        chk($sformatf("v%0d_ins", k), 32'(insert_pc), 32'd1);
        chk($sformatf("v%0d_ins_flush", k), 32'(pipe_flush), 32'd1);
        chk($sformatf("v%0d_npc", k), npc, v.e_npc);
        chk($sformatf("v%0d_cause", k), cause, v.e_cause);
        chk($sformatf("v%0d_epc", k), epc, v.e_epc);
        chk($sformatf("v%0d_intr", k), 32'(intr), 32'(v.e_intr));
        chk($sformatf("v%0d_tc", k), 32'(trap_commit), 32'(v.e_tc));
        chk($sformatf("v%0d_rc", k), 32'(ret_commit), 32'(v.e_rc));
        step();
        @(negedge CLK);
        chk($sformatf("v%0d_idle_busy", k), 32'(busy), 32'd0);
        chk($sformatf("v%0d_idle_ins", k), 32'(insert_pc), 32'd0);
        chk($sformatf("v%0d_idle_flush", k), 32'(pipe_flush), 32'd0);
        chk($sformatf("v%0d_idle_tc", k), 32'(trap_commit | ret_commit), 32'd0);
    endtask

    initial begin
        //        exc     exc_pc  mret irq     irq_en  gie int_pc  mtvec         mepc    npc           cause         epc    intr tc rc
        tbl[0]  = mk(9'h004, 32'h100, 0, 12'h000, 12'h000, 0, 32'h0,   32'h8000_0001, 32'h0,    32'h8000_0000, 32'h2,         32'h100, 0, 1, 0);
        tbl[1]  = mk(9'h10A, 32'h104, 0, 12'h000, 12'h000, 0, 32'h0,   32'h8000_0001, 32'h0,    32'h8000_0000, 32'h3,         32'h104, 0, 1, 0);
        tbl[2]  = mk(9'h000, 32'h0,   0, 12'h880, 12'hFFF, 1, 32'h200, 32'h4001,      32'h0,    32'h402C,      32'h8000_000B, 32'h200, 1, 1, 0);
        tbl[3]  = mk(9'h100, 32'h300, 0, 12'h001, 12'hFFF, 1, 32'h0,   32'h4001,      32'h0,    32'h4000,      32'hB,         32'h300, 0, 1, 0);
        tbl[4]  = mk(9'h000, 32'h0,   1, 12'h010, 12'hFFF, 0, 32'h0,   32'h4001,      32'h1234, 32'h1234,      32'hB,         32'h300, 0, 0, 1);
        tbl[5]  = mk(9'h000, 32'h0,   0, 12'h420, 12'h020, 1, 32'h500, 32'h1003,      32'h0,    32'h1000,      32'h8000_0005, 32'h500, 1, 1, 0);
        tbl[6]  = mk(9'h1F0, 32'h600, 0, 12'h000, 12'h000, 0, 32'h0,   32'h2000,      32'h0,    32'h2000,      32'hB,         32'h600, 0, 1, 0);
        tbl[7]  = mk(9'h0F0, 32'h604, 0, 12'h000, 12'h000, 0, 32'h0,   32'h2000,      32'h0,    32'h2000,      32'h6,         32'h604, 0, 1, 0);
        tbl[8]  = mk(9'h0B0, 32'h608, 0, 12'h000, 12'h000, 0, 32'h0,   32'h2000,      32'h0,    32'h2000,      32'h4,         32'h608, 0, 1, 0);
        tbl[9]  = mk(9'h0A0, 32'h60C, 0, 12'h000, 12'h000, 0, 32'h0,   32'h2000,      32'h0,    32'h2000,      32'h7,         32'h60C, 0, 1, 0);
        tbl[10] = mk(9'h020, 32'h610, 0, 12'h000, 12'h000, 0, 32'h0,   32'h2000,      32'h0,    32'h2000,      32'h5,         32'h610, 0, 1, 0);
        tbl[11] = mk(9'h003, 32'h614, 0, 12'h000, 12'h000, 0, 32'h0,   32'h2000,      32'h0,    32'h2000,      32'h1,         32'h614, 0, 1, 0);
        tbl[12] = mk(9'h005, 32'h618, 0, 12'h000, 12'h000, 0, 32'h0,   32'h2000,      32'h0,    32'h2000,      32'h2,         32'h618, 0, 1, 0);
        tbl[13] = mk(9'h000, 32'h0,   0, 12'h004, 12'hFFF, 1, 32'h700, 32'hFFFF_FFFD, 32'h0,    32'h4,         32'h8000_0002, 32'h700, 1, 1, 0);
        tbl[14] = mk(9'h040, 32'hABC, 1, 12'h000, 12'h000, 0, 32'h0,   32'h8000,      32'h1234, 32'h8000,      32'h6,         32'hABC, 0, 1, 0);
        tbl[15] = mk(9'h001, 32'h20,  0, 12'h002, 12'h000, 1, 32'h0,   32'h5006,      32'h0,    32'h5004,      32'h0,         32'h20,  0, 1, 0);

        // reset block
        RST = 1'b1; exc_vec = '0; exc_pc = '0; mret = 1'b0; irq = '0; irq_en = '0;
        global_ie = 1'b0; int_pc = '0; mtvec = '0; mepc = '0; pipe_empty = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flush", 32'(pipe_flush), 32'd0);
        chk("rst_ins", 32'(insert_pc), 32'd0);
        chk("rst_npc", npc, 32'd0);
        chk("rst_cause", cause, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_pend", 32'(irq_pending), 32'd0);
        step();
        RST = 1'b0;
        step();

        for (int k = 0; k < 16; k++) run_vec(tbl[k], k);

        // back-to-back: held request is retaken in the IDLE cycle after INSERT
        exc_vec = 9'h008; exc_pc = 32'h10; mtvec = 32'h100; pipe_empty = 1'b1;
        step();
        @(negedge CLK); chk("b2b_t1_flush", 32'(pipe_flush), 32'd1);
        step();
        @(negedge CLK); chk("b2b_t2_ins", 32'(insert_pc), 32'd1);
        chk("b2b_t2_cause", cause, 32'h3);
        step();
        @(negedge CLK); chk("b2b_t3_busy", 32'(busy), 32'd0);
        step();
        @(negedge CLK); chk("b2b_t4_busy", 32'(busy), 32'd1);
        step();
        exc_vec = '0;
        @(negedge CLK); chk("b2b_t5_ins", 32'(insert_pc), 32'd1);
        chk("b2b_t5_tc", 32'(trap_commit), 32'd1);
        step();
        @(negedge CLK); chk("b2b_t6_busy", 32'(busy), 32'd0);

        // edge-triggered source 3: latch while masked, clear on take, set-wins
        irq_en = 12'hFFF; global_ie = 1'b0; mtvec = 32'h4001; int_pc = 32'h880;
        irq[3] = 1'b1;
        step();
        irq[3] = 1'b0;
        @(negedge CLK); chk("edge_set", 32'(irq_pending[3]), 32'd1);
        step(); step();
        @(negedge CLK); chk("edge_hold", 32'(irq_pending[3]), 32'd1);
        chk("edge_masked_busy", 32'(busy), 32'd0);
        global_ie = 1'b1;
        step();
        global_ie = 1'b0;
        @(negedge CLK); chk("edge_drain_busy", 32'(busy), 32'd1);
        step();
        irq[3] = 1'b1;
        @(negedge CLK); chk("edge_ins", 32'(insert_pc), 32'd1);
        chk("edge_cause", cause, 32'h8000_0003);
        chk("edge_npc", npc, 32'h400C);
        chk("edge_epc", epc, 32'h880);
        step();
        irq[3] = 1'b0;
        @(negedge CLK); chk("edge_setwins", 32'(irq_pending[3]), 32'd1);
        chk("edge_idle", 32'(busy), 32'd0);
        global_ie = 1'b1;
        step();
        global_ie = 1'b0;
        step(); step();
        @(negedge CLK); chk("edge_cleared", 32'(irq_pending[3]), 32'd0);
        chk("edge_cleared_busy", 32'(busy), 32'd0);

        // mret with a slow drain; an exception raised during DRAIN is ignored
        mepc = 32'h1234; mret = 1'b1; pipe_empty = 1'b0;
        step();
        mret = 1'b0; exc_vec = 9'h004; exc_pc = 32'h999;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("mret_drain%0d_flush", i), 32'(pipe_flush), 32'd1);
            chk($sformatf("mret_drain%0d_ins", i), 32'(insert_pc), 32'd0);
            step();
        end
        pipe_empty = 1'b1; exc_vec = '0;
        @(negedge CLK); chk("mret_exit_ins", 32'(insert_pc), 32'd0);
        step();
        @(negedge CLK); chk("mret_ins", 32'(insert_pc), 32'd1);
        chk("mret_npc", npc, 32'h1234);
        chk("mret_rc", 32'(ret_commit), 32'd1);
        chk("mret_tc", 32'(trap_commit), 32'd0);
        chk("mret_epc", epc, 32'h880);
        chk("mret_cause", cause, 32'h8000_0003);
        step();
        @(negedge CLK); chk("mret_idle", 32'(busy), 32'd0);

        // reset in DRAIN aborts without a commit strobe
        exc_vec = 9'h004; exc_pc = 32'h40; pipe_empty = 1'b0;
        step();
        exc_vec = '0;
        @(negedge CLK); chk("rdr_busy", 32'(busy), 32'd1);
        RST = 1'b1;
        #1;
        chk("rdr_busy0", 32'(busy), 32'd0);
        chk("rdr_flush0", 32'(pipe_flush), 32'd0);
        chk("rdr_npc0", npc, 32'd0);
        chk("rdr_cause0", cause, 32'd0);
        chk("rdr_epc0", epc, 32'd0);
        chk("rdr_strobes0", 32'(insert_pc | trap_commit | ret_commit | intr), 32'd0);
        step();
        RST = 1'b0; pipe_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("rdr_post%0d", i), 32'(insert_pc | trap_commit | busy), 32'd0);
            step();
        end
        run_vec(tbl[0], 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
